// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receive-side controller sitting between a UART receive shift register
// and the host. It pulls completed bytes (with their framing/parity error
// flags) out of the receiver into a 4-entry FIFO and raises a level-based
// receive interrupt.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   enable_i         receive path enable; low flushes the FIFO
//   brg_sample_i     baud-rate sample tick (timeout time base)
//   rsr_full_i       receiver holds a completed byte
//   rsr_byte_i       held byte; ferr_i / perr_i its error flags
//   rsr_pull_o       one-cycle strobe telling the receiver its byte was taken
//   rd_i             host pop strobe for the FIFO head
//   rx_data_o        FIFO head byte; rx_ferr_o / rx_perr_o its error flags
//   rx_cnt_o         FIFO occupancy 0..4
//   int_mode_i       interrupt level: 00 >=1, 01 >=3, 10 ==4, 11 never
//   rx_int_o         receive interrupt request (level OR timeout)
//   rx_to_o          sticky receive timeout flag
//
// Build option: define UART_RX_TIMEOUT_EN to include the inactivity
// timeout counter (TO_TICKS sample ticks). Without it rx_to_o is tied low.
module uart_rx_ctrl #(
    parameter int unsigned TO_TICKS = 640
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable_i,
    input  logic       brg_sample_i,
    input  logic       rsr_full_i,
    input  logic [7:0] rsr_byte_i,
    input  logic       ferr_i,
    input  logic       perr_i,
    output logic       rsr_pull_o,
    input  logic       rd_i,
    output logic [7:0] rx_data_o,
    output logic       rx_ferr_o,
    output logic       rx_perr_o,
    output logic [2:0] rx_cnt_o,
    input  logic [1:0] int_mode_i,
    output logic       rx_int_o,
    output logic       rx_to_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_CAPT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic       pull_q, pull_d;
    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0] cnt_q, cnt_d;
    logic [9:0] mem_q [4];
    logic       push_s;
    logic       pop_s;
    logic       lvl_s;

`ifdef UART_RX_TIMEOUT_EN
    localparam int TO_W = $clog2(TO_TICKS + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_TICKS);
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_q, to_d;
`else
    logic            unused_cfg_s;
`endif

    // The push happens in the CAPT cycle, while the receiver still presents the byte.
    assign push_s = enable_i && (state_q == ST_CAPT);
    assign pop_s  = enable_i && rd_i && (cnt_q != 3'd0);

    // Next-state logic for FSM, pointers, occupancy and timeout.
    always_comb begin
        state_d  = ST_IDLE;
        pull_d   = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (!enable_i) begin
            wr_ptr_d = 2'd0;
            rd_ptr_d = 2'd0;
            cnt_d    = 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A full FIFO leaves rsr_full_i pending: receiver backpressure.
                    if (rsr_full_i && (cnt_q < 3'd4)) begin
                        state_d = ST_CAPT;
                        pull_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        pull_d  = 1'b0;
                    end
                end
                ST_CAPT: begin
                    state_d = ST_IDLE;
                    pull_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    pull_d  = 1'b0;
                end
            endcase
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + 2'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + 2'd1;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_d = cnt_q + 3'd1;
                2'b01:   cnt_d = cnt_q - 3'd1;
                default: cnt_d = cnt_q;
            endcase
        end
`ifdef UART_RX_TIMEOUT_EN
        to_cnt_d = to_cnt_q;
        to_d     = to_q;
        if (!enable_i) begin
            to_cnt_d = '0;
            to_d     = 1'b0;
        end else begin
            // Only genuine inactivity with data waiting advances the counter.
            if (push_s || pop_s || (cnt_q == 3'd0)) begin
                to_cnt_d = '0;
            end else if (brg_sample_i && (to_cnt_q != TO_MAX)) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end else begin
                to_cnt_d = to_cnt_q;
            end
            if (pop_s) begin
                to_d = 1'b0;
            end else if (to_cnt_q == TO_MAX) begin
                to_d = 1'b1;
            end else begin
                to_d = to_q;
            end
        end
`endif
    end

    // Control state registers; reset also cancels an in-flight capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pull_q   <= 1'b0;
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            cnt_q    <= 3'd0;
`ifdef UART_RX_TIMEOUT_EN
            to_cnt_q <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pull_q   <= pull_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
`ifdef UART_RX_TIMEOUT_EN
            to_cnt_q <= to_cnt_d;
            to_q     <= to_d;
`endif
        end
    end

    // FIFO storage; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {perr_i, ferr_i, rsr_byte_i};
        end
    end

    // Interrupt level decode from occupancy.
    always_comb begin
        lvl_s = 1'b0;
        case (int_mode_i)
            2'b00:   lvl_s = (cnt_q >= 3'd1);
            2'b01:   lvl_s = (cnt_q >= 3'd3);
            2'b10:   lvl_s = (cnt_q == 3'd4);
            default: lvl_s = 1'b0;
        endcase
    end

`ifdef UART_RX_TIMEOUT_EN
    assign rx_to_o = to_q;
`else
    assign rx_to_o      = 1'b0;
    assign unused_cfg_s = brg_sample_i | (TO_TICKS == 32'd0);
`endif

    assign rsr_pull_o = pull_q;
    assign rx_data_o  = mem_q[rd_ptr_q][7:0];
    assign rx_ferr_o  = mem_q[rd_ptr_q][8];
    assign rx_perr_o  = mem_q[rd_ptr_q][9];
    assign rx_cnt_o   = cnt_q;
    assign rx_int_o   = lvl_s | rx_to_o;

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter TO_TICKS, default 640, meaning brg_sample_i ticks of receive inactivity before a timeout (used only with UART_RX_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port enable_i  input  1  receive path enable.
REQ-005 SHALL have port brg_sample_i  input  1  baud-rate sample tick.
REQ-006 SHALL have port rsr_full_i  input  1  receiver holds a completed byte.
REQ-007 SHALL have port rsr_byte_i  input  8  received byte.
REQ-008 SHALL have port ferr_i  input  1  framing error of held byte.
REQ-009 SHALL have port perr_i  input  1  parity error of held byte.
REQ-010 SHALL have port rsr_pull_o  output  1  one-cycle pull strobe to receiver.
REQ-011 SHALL have port rd_i  input  1  host pop strobe for FIFO head.
REQ-012 SHALL have port rx_data_o  output  8  FIFO head byte.
REQ-013 SHALL have port rx_ferr_o  output  1  FIFO head framing error.
REQ-014 SHALL have port rx_perr_o  output  1  FIFO head parity error.
REQ-015 SHALL have port rx_cnt_o  output  3  FIFO occupancy, 0..4.
REQ-016 SHALL have port int_mode_i  input  2  interrupt level select.
REQ-017 SHALL have port rx_int_o  output  1  receive interrupt request.
REQ-018 SHALL have port rx_to_o  output  1  sticky receive timeout flag.

Function
REQ-019 SHALL hold a 4-entry FIFO of {perr, ferr, byte[7:0]} with 2-bit write/read pointers wrapping 3->0 and a 3-bit count.
REQ-020 SHALL run a 2-state FSM: IDLE -> CAPT when enable_i & rsr_full_i & count<4; CAPT -> IDLE unconditionally.
REQ-021 SHALL, in CAPT, assert rsr_pull_o for exactly that cycle and push {perr_i, ferr_i, rsr_byte_i}; rsr_pull_o is 0 in IDLE.
REQ-022 SHALL, when count==4, remain in IDLE with rsr_full_i pending (receiver backpressure); capture occurs on the first cycle with count<4.
REQ-023 SHALL pop on rd_i when count>0; rd_i with count==0 is ignored, with no pointer or count change.
REQ-024 SHALL, on simultaneous push and pop, advance both pointers and leave count unchanged.
REQ-025 SHALL drive rx_data_o/rx_ferr_o/rx_perr_o combinationally from the entry at the read pointer; value is don't-care when count==0.
REQ-026 SHALL compute rx_int_o combinationally from count: mode 00 count>=1, 01 count>=3, 10 count==4, 11 never; OR rx_to_o.
REQ-027 SHALL, while enable_i==0, force FSM to IDLE, pointers and count to 0, and rx_to_o to 0, with no pull issued.
REQ-028 SHALL make a pushed entry visible on rx_cnt_o and rx_data_o on the cycle after CAPT (1-cycle latency).

Reset
REQ-029 SHALL, on rst_n low, asynchronously set FSM=IDLE, pointers=0, count=0, rsr_pull_o=0, rx_to_o=0, timeout counter=0.
REQ-030 SHALL leave FIFO storage contents unreset; rx_data_o/rx_ferr_o/rx_perr_o are don't-care until the first push.
REQ-031 SHALL, with reset asserted mid-CAPT, drop rsr_pull_o immediately and discard the push.

Configuration
REQ-032 SHALL, with UART_RX_TIMEOUT_EN defined, count brg_sample_i ticks while count>0 and no push or pop occurs; any push, pop or count==0 clears the counter.
REQ-033 SHALL, with UART_RX_TIMEOUT_EN defined, set rx_to_o when the counter reaches TO_TICKS; rx_to_o clears on the next accepted pop or when enable_i==0.
REQ-034 SHALL, without UART_RX_TIMEOUT_EN, contain no timeout counter and tie rx_to_o to 0.

Verification
REQ-035 SHALL cover: rsr_full_i=1, byte 0xA5, perr=1 -> one-cycle rsr_pull_o, next cycle rx_cnt_o=1, rx_data_o=0xA5, rx_perr_o=1.
REQ-036 SHALL cover: 5 bytes 0x01..0x05 with no reads -> count=4, 5th held (no pull), one rd_i -> 0x05 captured, head=0x02.
REQ-037 SHALL cover: int_mode_i=01 -> rx_int_o low at count 2, high at count 3; mode 11 -> low at count 4.
REQ-038 SHALL cover: rd_i at count 0 -> count stays 0; rd_i in the CAPT cycle at count 2 -> count stays 2.
REQ-039 SHALL cover: enable_i dropped at count 3 -> count 0 next cycle, no pull while low.
REQ-040 SHALL cover (UART_RX_TIMEOUT_EN defined, TO_TICKS=8): 1 byte, 8 ticks idle -> rx_to_o=1, rx_int_o=1 with mode 10; rd_i -> rx_to_o=0.
